gpio_in_filter: RTL and testbench



---
 rtl/gpio_in_filter.sv | 116 +++++++++++
 tb/tb_gpio_in_filter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_filter.sv
// ---------------------------------------------------------------------------
// gpio_in_filter
//
// Input conditioning between the GPIO pads and the GPIO peripheral. Each pin
// is synchronised into clk_i by a plain 2-flop chain, optionally debounced
// (a new level must persist for N consecutive cycles before it is accepted),
// and produces single-cycle rise/fall pulses that coincide with the first
// cycle in which data_o shows the new level.
//
// Parameters
//   GPIO_NUM           number of pins handled (1..32)
//   CNT_W              width of the debounce counter and debounce_cycles_i
//
// Ports
//   clk_i              system clock
//   rst_ni             asynchronous active-low reset
//   pad_i              raw asynchronous pad levels
//   filt_en_i          per-pin debounce enable (1 = filtered)
//   debounce_cycles_i  required stable cycles N, shared by all pins
//   data_o             conditioned pin levels (registered)
//   rise_o             1-cycle pulse when data_o[i] goes 0->1
//   fall_o             1-cycle pulse when data_o[i] goes 1->0
// ---------------------------------------------------------------------------
module gpio_in_filter #(
    parameter int GPIO_NUM = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [GPIO_NUM-1:0] pad_i,
    input  logic [GPIO_NUM-1:0] filt_en_i,
    input  logic [CNT_W-1:0]    debounce_cycles_i,
    output logic [GPIO_NUM-1:0] data_o,
    output logic [GPIO_NUM-1:0] rise_o,
    output logic [GPIO_NUM-1:0] fall_o
);

    // Synchroniser stages: nothing but wires between them.
    logic [GPIO_NUM-1:0] s1_q;
    logic [GPIO_NUM-1:0] s2_q;

    // Filtered level and event pulses.
    logic [GPIO_NUM-1:0] data_q, data_d;
    logic [GPIO_NUM-1:0] rise_q, rise_d;
    logic [GPIO_NUM-1:0] fall_q, fall_d;

    // A zero threshold is treated like an unfiltered pin.
    logic dbc_zero;
    assign dbc_zero = (debounce_cycles_i == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pad_i;
            s2_q <= s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < GPIO_NUM; gi++) begin : g_pin
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W:0]   cnt_inc;
            logic             neff_one;
            logic             differ;
            logic             accept;

            // One extra bit so cnt + 1 never wraps before the comparison.
            assign cnt_inc  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
            assign neff_one = ~filt_en_i[gi] | dbc_zero;
            assign differ   = s2_q[gi] ^ data_q[gi];
            // With Neff = 1 the test cnt + 1 >= 1 always holds.
            assign accept   = neff_one | (cnt_inc >= {1'b0, debounce_cycles_i});

            assign data_d[gi] = (differ & accept) ? s2_q[gi] : data_q[gi];
            assign rise_d[gi] = differ & accept &  s2_q[gi];
            assign fall_d[gi] = differ & accept & ~s2_q[gi];

            // Any cycle of agreement restarts the count; the counter
            // saturates so a huge threshold never lets it wrap to 0.
            always_comb begin
                cnt_d = '0;
                if (differ && !accept) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_inc[CNT_W-1:0];
                end
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            data_q <= data_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign data_o = data_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_filter
//
// Table-driven bench: every row gives the inputs applied before one clock
// edge and the outputs expected just after it. Reset and multi-pin behaviour
// are covered by a hand-written sequence after the table.
// ---------------------------------------------------------------------------
module tb_gpio_in_filter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [15:0] pad_i;
    logic [15:0] filt_en_i;
    logic [15:0] debounce_cycles_i;
    logic [15:0] data_o;
    logic [15:0] rise_o;
    logic [15:0] fall_o;

    gpio_in_filter #(
        .GPIO_NUM(16),
        .CNT_W   (16)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pad_i            (pad_i),
        .filt_en_i        (filt_en_i),
        .debounce_cycles_i(debounce_cycles_i),
        .data_o           (data_o),
        .rise_o           (rise_o),
        .fall_o           (fall_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] pad;
        logic [15:0] filt;
        logic [15:0] dbc;
        logic [15:0] data;
        logic [15:0] rise;
        logic [15:0] fall;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input logic [15:0] pad, input logic [15:0] filt,
                        input logic [15:0] dbc, input logic [15:0] data,
                        input logic [15:0] rise, input logic [15:0] fall);
        vec_t v;
        v.pad  = pad;
        v.filt = filt;
        v.dbc  = dbc;
        v.data = data;
        v.rise = rise;
        v.fall = fall;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, required %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int idx,
                              input logic [15:0] d, input logic [15:0] r,
                              input logic [15:0] f);
        check({tag, "_data"}, idx, data_o, d);
        check({tag, "_rise"}, idx, rise_o, r);
        check({tag, "_fall"}, idx, fall_o, f);
        $display("%s step %0d: pad=%h filt=%h dbc=%h data=%h rise=%h fall=%h",
                 tag, idx, pad_i, filt_en_i, debounce_cycles_i, data_o, rise_o, fall_o);
    endtask

    // Hard bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] f;
        logic [15:0] d;

        // ---------------- table construction ----------------
        // Idle rows after reset release.
        for (int k = 0; k < 3; k++) push(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

        // Pin 0: unfiltered, then filtered with N=0 and N=1 (all 2-cycle latency).
        for (int m = 0; m < 3; m++) begin
            f = (m == 0) ? 16'h0000 : 16'h0001;
            d = (m == 2) ? 16'h0001 : 16'h0000;
            push(16'h1, f, d, 16'h0, 16'h0, 16'h0);
            push(16'h1, f, d, 16'h0, 16'h0, 16'h0);
            push(16'h1, f, d, 16'h1, 16'h1, 16'h0);
            push(16'h1, f, d, 16'h1, 16'h0, 16'h0);
            push(16'h1, f, d, 16'h1, 16'h0, 16'h0);
            push(16'h0, f, d, 16'h1, 16'h0, 16'h0);
            push(16'h0, f, d, 16'h1, 16'h0, 16'h0);
            push(16'h0, f, d, 16'h0, 16'h0, 16'h1);
            push(16'h0, f, d, 16'h0, 16'h0, 16'h0);
        end

        // Pin 3 debounced, N=5: rise accepted at E6, then fall at E6.
        for (int k = 0; k < 8; k++)
            push(16'h8, 16'h8, 16'd5, (k >= 6) ? 16'h8 : 16'h0,
                 (k == 6) ? 16'h8 : 16'h0, 16'h0);
        for (int k = 0; k < 8; k++)
            push(16'h0, 16'h8, 16'd5, (k >= 6) ? 16'h0 : 16'h8,
                 16'h0, (k == 6) ? 16'h8 : 16'h0);

        // Glitch: 4 high, 1 low, then high; accept only after 5 fresh cycles.
        for (int k = 0; k < 13; k++)
            push((k == 4) ? 16'h0 : 16'h8, 16'h8, 16'd5,
                 (k >= 11) ? 16'h8 : 16'h0, (k == 11) ? 16'h8 : 16'h0, 16'h0);

        // Huge threshold held 10 cycles, then lowered to 4: accept next edge.
        for (int k = 0; k < 10; k++) push(16'h0, 16'h8, 16'hFFFF, 16'h8, 16'h0, 16'h0);
        push(16'h0, 16'h8, 16'd4, 16'h0, 16'h0, 16'h8);
        push(16'h0, 16'h8, 16'd4, 16'h0, 16'h0, 16'h0);

        // Filter disabled mid-count: accept on that edge.
        for (int k = 0; k < 4; k++) push(16'h8, 16'h8, 16'd5, 16'h0, 16'h0, 16'h0);
        push(16'h8, 16'h0, 16'd5, 16'h8, 16'h8, 16'h0);
        push(16'h8, 16'h0, 16'd5, 16'h8, 16'h0, 16'h0);

        // Threshold raised 3 -> 6 mid-count: count continues to 6.
        for (int k = 0; k < 9; k++)
            push(16'h0, 16'h8, (k < 3) ? 16'd3 : 16'd6, (k >= 7) ? 16'h0 : 16'h8,
                 16'h0, (k == 7) ? 16'h8 : 16'h0);

        // ---------------- reset state ----------------
        rst_ni            = 1'b0;
        pad_i             = 16'h0;
        filt_en_i         = 16'h0;
        debounce_cycles_i = 16'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check_outs("reset", 0, 16'h0, 16'h0, 16'h0);
        rst_ni = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            pad_i             = vecs[i].pad;
            filt_en_i         = vecs[i].filt;
            debounce_cycles_i = vecs[i].dbc;
            @(posedge clk_i);
            #1;
            check_outs("vec", i, vecs[i].data, vecs[i].rise, vecs[i].fall);
            check("no_both", i, rise_o & fall_o, 16'h0);
        end

        // ---------------- reset mid-count, multi-pin release ----------------
        pad_i             = 16'h0001;
        filt_en_i         = 16'h0008;
        debounce_cycles_i = 16'd5;
        repeat (4) @(posedge clk_i);
        #1;
        check_outs("pre_rst", 0, 16'h0001, 16'h0, 16'h0);
        pad_i = 16'h0009;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            check_outs("pending", k, 16'h0001, 16'h0, 16'h0);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        check_outs("async_rst", 0, 16'h0, 16'h0, 16'h0);
        pad_i     = 16'h8001;
        filt_en_i = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            check_outs("in_rst", k, 16'h0, 16'h0, 16'h0);
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_i);
            #1;
            check_outs("release", k, (k >= 2) ? 16'h8001 : 16'h0,
                       (k == 2) ? 16'h8001 : 16'h0, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
